// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32 subset datapath (lb, ori, sb,
// R-type, bne). Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK, drives the shared datapath strobes, traps on illegal opcodes or
// memory timeouts and counts retired instructions.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | instruction read in flight, IR loads when memory is ready
// DECODE    | opcode latched into op_q and checked for legality
// EXECUTE   | ALU operation; bne resolves and retires here
// MEMORY    | lb read / sb write in flight; sb retires on ready
// WRITEBACK | register file write (ALU or load data), PC+4, retire
// TRAP      | terminal; only reset leaves it
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [1:0]         alu_op,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_LB  = 7'b0000011;
    localparam logic [6:0] OP_ORI = 7'b0010011;
    localparam logic [6:0] OP_SB  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BNE = 7'b1100011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_FETCH   = 2'b10;
    localparam logic [1:0] CAUSE_MEMORY  = 2'b11;

    // The wait counter never passes MEM_TIMEOUT-1: the cycle that would reach
    // MEM_TIMEOUT leaves the state instead, which clears it.
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [6:0]           op_q, op_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 trap_q, trap_d;
    logic [1:0]           cause_q, cause_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic                 retire;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_LB) || (op == OP_ORI) || (op == OP_SB) ||
               (op == OP_R)  || (op == OP_BNE);
    endfunction

    // Next-state, timeout, trap capture and retire counting.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_FETCH;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                case (op_q)
                    OP_LB, OP_SB:  state_d = ST_MEMORY;
                    OP_ORI, OP_R:  state_d = ST_WRITEBACK;
                    OP_BNE: begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    default: begin
                        // op_q is legal by construction; treat corruption as illegal
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    if (op_q == OP_SB) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_MEMORY;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: state_d = ST_TRAP;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEMORY) && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end

        retired_d = retire ? retired_q + COUNT_W'(1) : retired_q;
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    // Datapath strobes decoded from the current state and latched opcode;
    // everything is held low while reset is asserted.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                ST_EXECUTE: begin
                    case (op_q)
                        OP_LB, OP_SB: alu_src = 1'b1;
                        OP_ORI: begin
                            alu_src = 1'b1;
                            alu_op  = 2'b10;
                        end
                        OP_R:   alu_op = 2'b10;
                        OP_BNE: begin
                            alu_op   = 2'b01;
                            pc_write = 1'b1;
                            pc_src   = ~zero;
                        end
                        default: ;
                    endcase
                end
                ST_MEMORY: begin
                    mem_read  = (op_q == OP_LB);
                    mem_write = (op_q == OP_SB);
                    pc_write  = mem_ready && (op_q == OP_SB);
                end
                ST_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LB);
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32 subset datapath (lb, ori, sb, add/and/sll, bne). It breaks each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the shared datapath strobes: PC, IR, register file, ALU mux/op and data memory. It waits on a single memory ready handshake and traps on illegal opcodes or memory timeouts. It also keeps a count of retired instructions.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive wait cycles allowed in FETCH or MEMORY before a trap (must be ≥ 2).
- COUNT_W, 16: width of the retired-instruction counter.
- clock  in  1  system clock; all state updates occur on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clock.
- opcode  in  7  instruction[6:0] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in EXECUTE.
- mem_ready  in  1  memory completes the current read or write this cycle.
- state  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
- mem_read, mem_write  out  1  data/instruction memory request strobes.
- ir_write  out  1  load the IR this cycle.
- pc_write  out  1  update the PC this cycle.
- pc_src  out  1  PC source select: 0 = PC+4, 1 = branch target.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback mux select: 1 = memory data, 0 = ALU result.
- alu_src  out  1  ALU operand B select: 1 = immediate, 0 = rs2.
- alu_op  out  2  ALU op class: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- trap  out  1  sticky; set on entry to TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 memory timeout.
- retired  out  COUNT_W  count of completed instructions; wraps modulo 2^COUNT_W.

## Operation
- Legal opcodes:
  - 0000011 lb
  - 0010011 ori
  - 0100011 sb
  - 0110011 R-type
  - 1100011 bne
- Opcode latching: `opcode` is latched into op_q in DECODE. Every later state decodes from op_q only.
- Output rule: all strobes are a combinational function of state, op_q, zero and mem_ready. Any strobe not listed for a state is 0.
- FETCH
  - mem_read=1.
  - When mem_ready=1: ir_write=1, next state DECODE.
- DECODE
  - No strobes.
  - Legal opcode: next EXECUTE.
  - Illegal opcode: next TRAP, trap_cause=01.
- EXECUTE
  - lb/sb: alu_src=1, alu_op=00 (address calculation); next MEMORY.
  - ori: alu_src=1, alu_op=10; next WRITEBACK.
  - R-type: alu_src=0, alu_op=10; next WRITEBACK.
  - bne: alu_src=0, alu_op=01, pc_write=1, pc_src=~zero; retire; next FETCH.
- MEMORY
  - lb: mem_read=1. sb: mem_write=1.
  - While mem_ready=0, remain in MEMORY.
  - On mem_ready=1, sb: pc_write=1, pc_src=0, retire, next FETCH.
  - On mem_ready=1, lb: next WRITEBACK.
- WRITEBACK
  - reg_write=1, mem_to_reg=(op_q==lb), pc_write=1, pc_src=0.
  - Retire; next FETCH.
- TRAP
  - All strobes 0. trap=1 and trap_cause are held.
  - Only reset exits TRAP.
- Timeout
  - A wait counter increments each cycle spent in FETCH or MEMORY with mem_ready=0.
  - It clears on every state change.
  - If MEM_TIMEOUT consecutive cycles pass with mem_ready=0, the next edge enters TRAP. trap_cause=10 if the wait was in FETCH, 11 if in MEMORY.
  - If mem_ready=1 arrives on the final allowed cycle, ready wins and no trap occurs.
- Retire: retired increments by 1 on the edge that ends the cycle containing the instruction's final pc_write. It wraps from all-ones to 0 with no flag.

## Timing
- Reset values, applied on the edge with reset=1:
  - state=FETCH, op_q=0, wait counter=0, trap=0, trap_cause=00, retired=0.
- Strobes during reset: all strobes (mem_read included) are forced to 0 in any cycle where reset=1.
- Fetch start: the first mem_read=1 appears in the first cycle after reset deasserts.
- Reset mid-instruction or in TRAP: aborts immediately, returns to FETCH and produces no retire.
- Cycles per instruction, with mem_ready high on first request:
  - bne: 3
  - sb, ori, R-type: 4
  - lb: 5
- Memory stalls: each cycle of mem_ready=0 in FETCH or MEMORY adds exactly one cycle.
- Strobe exclusivity: mem_read and mem_write are never high together. ir_write occurs only in FETCH. reg_write occurs only in WRITEBACK.

## Test plan
- R-type, mem_ready held 1:
  - Stimulus: reset, then opcode=0110011.
  - Required: states 0,1,2,4,0; reg_write=1 only in cycle 4; alu_op=10, alu_src=0 in EXECUTE; retired=1 after 4 cycles.
- lb with stall:
  - Stimulus: opcode=0000011, mem_ready low for 3 MEMORY cycles.
  - Required: MEMORY lasts 4 cycles; WRITEBACK has mem_to_reg=1 and reg_write=1; total 8 cycles.
- bne, both outcomes:
  - Stimulus: zero=0, then zero=1.
  - Required: pc_write=1 in EXECUTE with pc_src=1, then pc_src=0; alu_op=01; 3 cycles each.
- Illegal opcode:
  - Stimulus: opcode=1111111.
  - Required: TRAP two cycles after fetch completes, trap_cause=01, all strobes 0; persists for 100 cycles; reset returns state to FETCH, trap=0.
- Timeout, MEM_TIMEOUT=4:
  - Stimulus: mem_ready held 0 in FETCH.
  - Required: TRAP after 4 FETCH cycles, trap_cause=10.
- Timeout boundary, MEM_TIMEOUT=4:
  - Stimulus: mem_ready=1 on the 4th FETCH cycle.
  - Required: DECODE next, no trap.
- Counter wrap, COUNT_W=2:
  - Stimulus: 5 sb instructions.
  - Required: retired sequence 1,2,3,0,1.
- Reset mid-instruction:
  - Stimulus: reset asserted during MEMORY of an sb.
  - Required: retired unchanged from before the sb; mem_write=0 in the reset cycle; FETCH afterwards.
